result_packer: RTL and testbench
================================

// Module: result_packer
// PURPOSE
// - Parametrised result buffer: packs successive ALU results (LANE_W bits each) into
//   one WORD_W memory word and presents finished words on a valid/ready interface.
// - Sits between ALU result path and memory write controller. Adds lane auto-increment,
//   directed lane select, partial-word flush, one-word output staging and backpressure.
// PARAMETERS
// - LANE_W   default DATA_W (32)         width of one ALU result
// - WORD_W   default MEM_WORD_SIZE (64)  width of one packed memory word
// - LANES    derived WORD_W/LANE_W        lanes per word; elaboration error if WORD_W%LANE_W!=0
// - IDX_W    derived (LANES>1)?$clog2(LANES):1
// PORTS
// - clk_i           in   1       clock
// - rst_i           in   1       reset, synchronous, active-high
// - result_i        in   LANE_W  result from ALU
// - result_valid_i  in   1       result_i valid this cycle
// - result_ready_o  out  1       packer can accept a result
// - mode_i          in   1       0 = auto lane pointer, 1 = directed (lane_sel_i)
// - lane_sel_i      in   IDX_W   target lane in directed mode; lane 0 = bits [LANE_W-1:0]
// - flush_i         in   1       emit current partial word
// - word_o          out  WORD_W  packed word
// - word_valid_o    out  1       word_o valid
// - word_ready_i    in   1       consumer accepts word_o
// - lane_ptr_o      out  IDX_W   next lane in auto mode
// BEHAVIOUR
// - Reset (sync, active-high, posedge clk_i): assembly reg, lane mask, lane_ptr_o, word_o
//   all 0; word_valid_o 0; state FILL; result_ready_o 1 from first cycle after reset.
//   Reset mid-word or mid-handshake discards everything, no word emitted.
// - Accept = result_valid_i & result_ready_o. Lane = lane_ptr_o (mode 0) or lane_sel_i (mode 1).
//   Accepted result written into that lane; lane mask bit set. Mode 0: lane_ptr_o wraps
//   LANES-1 -> 0. Mode 1: lane_ptr_o unchanged; rewriting a set lane overwrites, no completion.
// - Word completes when lane mask becomes all-ones, or flush_i with non-empty mask (after
//   including any same-cycle accepted result). flush_i with empty mask and no accept: no-op.
// - On completion: unwritten lanes are 0; assembly reg, mask and lane_ptr_o clear to 0.
// - Output slot: word_valid_o held with word_o stable until word_valid_o & word_ready_i.
// - States: FILL -- assembling; completion with slot free (empty or draining this cycle)
//   loads slot; word_valid_o rises next cycle (1-cycle latency). Completion with slot full
//   and not draining -> HOLD. HOLD -- result_ready_o 0, flush_i ignored; on slot drain,
//   completed word moves to slot, -> FILL.
// - result_ready_o = (state==FILL). Full throughput: 1 result/cycle with word_ready_i high.
// - mode_i change mid-word allowed; mask governs completion.
// CONFIGURATION
// - RESULT_PACKER_LANE_MASK_EN defined: extra port word_mask_o out LANES, lane mask
//   registered with word_o (bit i = lane i written), reset 0. Undefined: no port, no logic.
// STRUCTURE
// - calculator_pkg: DATA_W, MEM_WORD_SIZE (existing); add packer_state_e {FILL, HOLD}.
// - Single module; no sub-module (assembly reg + output slot + 2-state FSM).
// TESTING
// - Auto, LANE_W=32/WORD_W=64, word_ready_i=1: results 0x11111111, 0x22222222 ->
//   next cycle word_o=0x22222222_11111111, word_valid_o=1 for 1 cycle.
// - Directed: lane_sel_i=1 writes 0xAAAA0000, then 0xBBBB0000 to lane 1, then 0x1234 to
//   lane 0 -> word_o=0xBBBB0000_00001234 only after third write.
// - Flush: one result 0xDEADBEEF then flush_i -> word_o=0x00000000_DEADBEEF;
//   flush_i with empty mask -> word_valid_o stays 0.
// - Backpressure: word_ready_i=0, 6 results streamed -> 2 words staged, result_ready_o=0
//   after 4th accept; word_o stable; word_ready_i=1 -> words drain in order, ready returns.
// - Reset mid-word: 1 result, rst_i=1 one cycle -> mask/lane_ptr_o=0, no word emitted;
//   next two results form a clean word.
// - LANE_W=16/WORD_W=64: results 1,2,3,4 -> word_o=0x0004_0003_0002_0001; with
//   RESULT_PACKER_LANE_MASK_EN, flush after 3 -> word_mask_o=4'b0111.

Source files
------------

// File: rtl/calculator_pkg.sv
`default_nettype none
// ============================================================================
// Package     : calculator_pkg
// Description : Shared calculator widths and the result packer state type.
//               DATA_W        - width of one ALU result
//               MEM_WORD_SIZE - width of one memory word
//               packer_state_e - FILL (assembling) / HOLD (completed word
//                                waiting for the output slot)
// Revision    : 1.0 - initial release
// ============================================================================
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

endpackage
`default_nettype wire

// File: rtl/result_packer_if.sv
`default_nettype none
// ============================================================================
// Interface   : result_packer_if
// Description : Result-in / word-out signal bundle of the result packer.
//               result_i, result_valid_i, result_ready_o : ALU result handshake
//               mode_i, lane_sel_i, flush_i              : lane control
//               word_o, word_valid_o, word_ready_i       : packed word handshake
//               lane_ptr_o                               : next auto lane
//               word_mask_o (RESULT_PACKER_LANE_MASK_EN) : lanes written in word_o
//               slave  modport : the packer
//               master modport : the ALU / memory-controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface result_packer_if #(
  parameter int LANE_W = 32,
  parameter int WORD_W = 64
);

  localparam int LANES = WORD_W / LANE_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANE_W-1:0] result_i;
  logic              result_valid_i;
  logic              result_ready_o;
  logic              mode_i;
  logic [IDX_W-1:0]  lane_sel_i;
  logic              flush_i;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_ready_i;
  logic [IDX_W-1:0]  lane_ptr_o;
`ifdef RESULT_PACKER_LANE_MASK_EN
  logic [LANES-1:0]  word_mask_o;
`endif

  modport slave (
    input  result_i, result_valid_i, mode_i, lane_sel_i, flush_i, word_ready_i,
    output result_ready_o, word_o, word_valid_o, lane_ptr_o
`ifdef RESULT_PACKER_LANE_MASK_EN
    , output word_mask_o
`endif
  );

  modport master (
    output result_i, result_valid_i, mode_i, lane_sel_i, flush_i, word_ready_i,
    input  result_ready_o, word_o, word_valid_o, lane_ptr_o
`ifdef RESULT_PACKER_LANE_MASK_EN
    , input word_mask_o
`endif
  );

endinterface
`default_nettype wire

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// Module      : result_packer
// Description : Packs successive LANE_W-bit ALU results into WORD_W-bit memory
//               words and presents finished words on a valid/ready output.
//               Lanes are chosen by an auto-incrementing pointer (mode_i=0) or
//               by lane_sel_i (mode_i=1). A word completes when every lane has
//               been written or on flush_i with at least one lane written.
//               One output slot plus one pending word give backpressure.
// Ports       : clk_i - clock
//               rst_i - synchronous active-high reset
//               bus   - result_packer_if.slave (see interface header)
// Options     : RESULT_PACKER_LANE_MASK_EN - adds bus.word_mask_o, the set of
//               lanes written in word_o.
// Revision    : 1.0 - initial release
// ============================================================================
module result_packer
  import calculator_pkg::*;
#(
  parameter int LANE_W = DATA_W,
  parameter int WORD_W = MEM_WORD_SIZE
) (
  input  wire             clk_i,
  input  wire             rst_i,
  result_packer_if.slave  bus
);

  localparam int LANES = WORD_W / LANE_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  generate
    if ((WORD_W % LANE_W) != 0) begin : g_bad_width
      $error("result_packer: WORD_W must be a multiple of LANE_W");
    end
  endgenerate

  packer_state_e     state_q, state_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [WORD_W-1:0] slot_q, slot_d;
  logic              slot_valid_q, slot_valid_d;
  logic [WORD_W-1:0] pend_q, pend_d;
`ifdef RESULT_PACKER_LANE_MASK_EN
  logic [LANES-1:0]  slot_mask_q, slot_mask_d;
  logic [LANES-1:0]  pend_mask_q, pend_mask_d;
`endif

  logic              accept;
  logic              drain;
  logic              slot_free;
  logic              complete;
  logic [IDX_W-1:0]  lane;
  logic [WORD_W-1:0] wr_word;
  logic [LANES-1:0]  wr_mask;

  assign accept    = bus.result_valid_i && (state_q == FILL);
  assign drain     = slot_valid_q && bus.word_ready_i;
  // The slot can take a new word if it is empty or is handing its word off now.
  assign slot_free = !slot_valid_q || drain;
  assign lane      = bus.mode_i ? bus.lane_sel_i : ptr_q;

  always_comb begin
    wr_word = asm_q;
    wr_mask = mask_q;
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane == IDX_W'(i)) begin
          wr_word[i*LANE_W +: LANE_W] = bus.result_i;
          wr_mask[i]                  = 1'b1;
        end
      end
    end
    // Flush sees the mask including a result accepted in the same cycle.
    complete = (state_q == FILL) &&
               ((accept && (&wr_mask)) || (bus.flush_i && (|wr_mask)));
  end

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    mask_d       = mask_q;
    ptr_d        = ptr_q;
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    pend_d       = pend_q;
`ifdef RESULT_PACKER_LANE_MASK_EN
    slot_mask_d  = slot_mask_q;
    pend_mask_d  = pend_mask_q;
`endif

    if (drain) begin
      slot_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (complete) begin
          // Cleared assembly register guarantees unwritten lanes read as 0.
          asm_d  = '0;
          mask_d = '0;
          ptr_d  = '0;
          if (slot_free) begin
            slot_d       = wr_word;
            slot_valid_d = 1'b1;
`ifdef RESULT_PACKER_LANE_MASK_EN
            slot_mask_d  = wr_mask;
`endif
          end else begin
            pend_d  = wr_word;
`ifdef RESULT_PACKER_LANE_MASK_EN
            pend_mask_d = wr_mask;
`endif
            state_d = HOLD;
          end
        end else if (accept) begin
          asm_d  = wr_word;
          mask_d = wr_mask;
          if (!bus.mode_i) begin
            ptr_d = (ptr_q == IDX_W'(LANES - 1)) ? '0 : ptr_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (drain) begin
          slot_d       = pend_q;
          slot_valid_d = 1'b1;
`ifdef RESULT_PACKER_LANE_MASK_EN
          slot_mask_d  = pend_mask_q;
`endif
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FILL;
      asm_q        <= '0;
      mask_q       <= '0;
      ptr_q        <= '0;
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      pend_q       <= '0;
`ifdef RESULT_PACKER_LANE_MASK_EN
      slot_mask_q  <= '0;
      pend_mask_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      pend_q       <= pend_d;
`ifdef RESULT_PACKER_LANE_MASK_EN
      slot_mask_q  <= slot_mask_d;
      pend_mask_q  <= pend_mask_d;
`endif
    end
  end

  assign bus.result_ready_o = (state_q == FILL);
  assign bus.word_o         = slot_q;
  assign bus.word_valid_o   = slot_valid_q;
  assign bus.lane_ptr_o     = ptr_q;
`ifdef RESULT_PACKER_LANE_MASK_EN
  assign bus.word_mask_o    = slot_mask_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_packer
// Description : Directed scoreboard bench for result_packer. Instance A uses
//               32-bit lanes in a 64-bit word, instance B 16-bit lanes.
//               Expected words are queued as stimulus is issued; a monitor per
//               instance pops and compares on every output handshake and
//               checks word_o stays stable while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_packer;
  import calculator_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_packer_if #(.LANE_W(32), .WORD_W(64)) a_if ();
  result_packer_if #(.LANE_W(16), .WORD_W(64)) b_if ();

  result_packer #(.LANE_W(32), .WORD_W(64)) u_a (.clk_i(clk), .rst_i(rst), .bus(a_if));
  result_packer #(.LANE_W(16), .WORD_W(64)) u_b (.clk_i(clk), .rst_i(rst), .bus(b_if));

  typedef struct {
    logic [63:0] word;
    logic [3:0]  mask;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  logic        a_stall = 1'b0, b_stall = 1'b0;
  logic [63:0] a_prev, b_prev;

  always @(negedge clk) begin
    if (rst) begin
      a_stall = 1'b0;
    end else begin
      if (a_stall) begin
        chk("a_stall_valid", 64'(a_if.word_valid_o), 64'd1);
        chk("a_stall_word", a_if.word_o, a_prev);
      end
      if (a_if.word_valid_o && a_if.word_ready_i) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_word: got %h expected none", a_if.word_o);
        end else begin
          ea = qa.pop_front();
          chk("a_word", a_if.word_o, ea.word);
`ifdef RESULT_PACKER_LANE_MASK_EN
          chk("a_mask", 64'(a_if.word_mask_o), 64'(ea.mask[1:0]));
`endif
        end
      end
      a_stall = a_if.word_valid_o && !a_if.word_ready_i;
      a_prev  = a_if.word_o;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_stall = 1'b0;
    end else begin
      if (b_stall) begin
        chk("b_stall_word", b_if.word_o, b_prev);
      end
      if (b_if.word_valid_o && b_if.word_ready_i) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_word: got %h expected none", b_if.word_o);
        end else begin
          eb = qb.pop_front();
          chk("b_word", b_if.word_o, eb.word);
`ifdef RESULT_PACKER_LANE_MASK_EN
          chk("b_mask", 64'(b_if.word_mask_o), 64'(eb.mask));
`endif
        end
      end
      b_stall = b_if.word_valid_o && !b_if.word_ready_i;
      b_prev  = b_if.word_o;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic put_a(input logic [31:0] d, input logic m, input logic s, input logic fl);
    int n;
    a_if.result_i       = d;
    a_if.result_valid_i = 1'b1;
    a_if.mode_i         = m;
    a_if.lane_sel_i     = s;
    a_if.flush_i        = fl;
    n = 0;
    @(negedge clk);
    while (!a_if.result_ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!a_if.result_ready_o) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout: got ready=0 expected ready=1 within 40 cycles");
    end
    @(posedge clk);
    #1;
    a_if.result_valid_i = 1'b0;
    a_if.flush_i        = 1'b0;
    a_if.mode_i         = 1'b0;
  endtask

  task automatic put_b(input logic [15:0] d);
    int n;
    b_if.result_i       = d;
    b_if.result_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b_if.result_ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!b_if.result_ready_o) begin
      checks++; errors++;
      $display("FAIL b_accept_timeout: got ready=0 expected ready=1 within 40 cycles");
    end
    @(posedge clk);
    #1;
    b_if.result_valid_i = 1'b0;
  endtask

  task automatic flush_a();
    a_if.flush_i = 1'b1;
    @(posedge clk);
    #1;
    a_if.flush_i = 1'b0;
  endtask

  task automatic flush_b();
    b_if.flush_i = 1'b1;
    @(posedge clk);
    #1;
    b_if.flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_if.result_i = '0; a_if.result_valid_i = 1'b0; a_if.mode_i = 1'b0;
    a_if.lane_sel_i = '0; a_if.flush_i = 1'b0; a_if.word_ready_i = 1'b1;
    b_if.result_i = '0; b_if.result_valid_i = 1'b0; b_if.mode_i = 1'b0;
    b_if.lane_sel_i = '0; b_if.flush_i = 1'b0; b_if.word_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("a_rst_ready", 64'(a_if.result_ready_o), 64'd1);
    chk("a_rst_valid", 64'(a_if.word_valid_o), 64'd0);
    chk("a_rst_word",  a_if.word_o, 64'd0);
    chk("a_rst_ptr",   64'(a_if.lane_ptr_o), 64'd0);
    chk("b_rst_ready", 64'(b_if.result_ready_o), 64'd1);
`ifdef RESULT_PACKER_LANE_MASK_EN
    chk("a_rst_mask",  64'(a_if.word_mask_o), 64'd0);
`endif

    // Auto mode, two lanes
    qa.push_back('{64'h22222222_11111111, 4'b0011});
    put_a(32'h11111111, 1'b0, 1'b0, 1'b0);
    chk("a_auto_ptr1",  64'(a_if.lane_ptr_o), 64'd1);
    chk("a_auto_nov",   64'(a_if.word_valid_o), 64'd0);
    put_a(32'h22222222, 1'b0, 1'b0, 1'b0);
    chk("a_auto_ptr_wrap", 64'(a_if.lane_ptr_o), 64'd0);
    chk("a_auto_valid", 64'(a_if.word_valid_o), 64'd1);
    chk("a_auto_word",  a_if.word_o, 64'h22222222_11111111);
    idle(1);
    chk("a_auto_valid_1cyc", 64'(a_if.word_valid_o), 64'd0);

    // Directed mode with overwrite of lane 1
    put_a(32'hAAAA0000, 1'b1, 1'b1, 1'b0);
    put_a(32'hBBBB0000, 1'b1, 1'b1, 1'b0);
    chk("a_dir_no_word", 64'(a_if.word_valid_o), 64'd0);
    chk("a_dir_ptr",     64'(a_if.lane_ptr_o), 64'd0);
    qa.push_back('{64'hBBBB0000_00001234, 4'b0011});
    put_a(32'h00001234, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Flush a partial word, then an empty flush
    qa.push_back('{64'h00000000_DEADBEEF, 4'b0001});
    put_a(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("a_flush_ptr1", 64'(a_if.lane_ptr_o), 64'd1);
    flush_a();
    chk("a_flush_ptr_clr", 64'(a_if.lane_ptr_o), 64'd0);
    chk("a_flush_valid",   64'(a_if.word_valid_o), 64'd1);
    idle(2);
    flush_a();
    chk("a_empty_flush", 64'(a_if.word_valid_o), 64'd0);
    idle(1);

    // Flush in the same cycle as an accept includes that result
    qa.push_back('{64'h00000000_55555555, 4'b0001});
    put_a(32'h55555555, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Backpressure: two words staged, then drain in order
    a_if.word_ready_i = 1'b0;
    put_a(32'h00000101, 1'b0, 1'b0, 1'b0);
    put_a(32'h00000102, 1'b0, 1'b0, 1'b0);
    put_a(32'h00000103, 1'b0, 1'b0, 1'b0);
    put_a(32'h00000104, 1'b0, 1'b0, 1'b0);
    chk("a_bp_ready_low", 64'(a_if.result_ready_o), 64'd0);
    chk("a_bp_valid",     64'(a_if.word_valid_o), 64'd1);
    chk("a_bp_word",      a_if.word_o, 64'h00000102_00000101);
    chk("a_bp_ptr",       64'(a_if.lane_ptr_o), 64'd0);
    idle(3);
    chk("a_bp_still_low", 64'(a_if.result_ready_o), 64'd0);
    qa.push_back('{64'h00000102_00000101, 4'b0011});
    qa.push_back('{64'h00000104_00000103, 4'b0011});
    qa.push_back('{64'h00000106_00000105, 4'b0011});
    a_if.word_ready_i = 1'b1;
    put_a(32'h00000105, 1'b0, 1'b0, 1'b0);
    put_a(32'h00000106, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("a_bp_ready_back", 64'(a_if.result_ready_o), 64'd1);

    // Reset mid-word discards the partial word
    put_a(32'h00000077, 1'b0, 1'b0, 1'b0);
    chk("a_mid_ptr1", 64'(a_if.lane_ptr_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("a_rst_mid_ptr",   64'(a_if.lane_ptr_o), 64'd0);
    chk("a_rst_mid_valid", 64'(a_if.word_valid_o), 64'd0);
    qa.push_back('{64'h00000099_00000088, 4'b0011});
    put_a(32'h00000088, 1'b0, 1'b0, 1'b0);
    put_a(32'h00000099, 1'b0, 1'b0, 1'b0);
    idle(2);

    // 16-bit lanes: full word, then flush after three lanes
    qb.push_back('{64'h0004_0003_0002_0001, 4'b1111});
    put_b(16'd1);
    put_b(16'd2);
    put_b(16'd3);
    put_b(16'd4);
    idle(2);
    qb.push_back('{64'h0000_0003_0002_0001, 4'b0111});
    put_b(16'd1);
    put_b(16'd2);
    put_b(16'd3);
    chk("b_ptr3", 64'(b_if.lane_ptr_o), 64'd3);
    flush_b();
    chk("b_flush_ptr_clr", 64'(b_if.lane_ptr_o), 64'd0);
    idle(3);

    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
